// File: rtl/GLOBAL_PARAM.sv
// Shared PE instruction bundle and phase encodings used by the
// AGU scheduler and its instruction FIFO.
package GLOBAL_PARAM;

    localparam logic [1:0] PH_FWD = 2'b00;
    localparam logic [1:0] PH_BWD = 2'b01;
    localparam logic [1:0] PH_UPD = 2'b10;

    typedef struct packed {
        logic [2:0] mode;
        logic [7:0] idx_cnt;
        logic [7:0] trip_cnt;
        logic       is_new;
        logic [3:0] pad_code;
        logic       cut_y;
        logic       new_idx;
    } pe_inst_t;

    localparam int PE_INST_W = $bits(pe_inst_t);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWITCH,
        S_START,
        S_WAIT_DONE
    } sched_state_e;

endpackage

// File: rtl/pe_inst_fifo.sv
// Synchronous instruction FIFO; head is read from registered storage,
// so a push becomes visible one cycle later.
module pe_inst_fifo
    import GLOBAL_PARAM::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  pe_inst_t din,
    input  logic     pop,
    output pe_inst_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    pe_inst_t        mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     wr_ptr_d;
    logic [AW:0]     rd_ptr_q;
    logic [AW:0]     rd_ptr_d;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer MSB distinguishes full from empty on equal indices
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pe_agu_sched.sv
// Per-PE scheduler: queues instructions, sequences the index ping-pong
// swap and issues one AGU start at a time while tracking progress.
module pe_agu_sched
    import GLOBAL_PARAM::*;
#(
    parameter int INST_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [2:0]       inst_mode,
    input  logic [7:0]       inst_idx_cnt,
    input  logic [7:0]       inst_trip_cnt,
    input  logic             inst_is_new,
    input  logic [3:0]       inst_pad_code,
    input  logic             inst_cut_y,
    input  logic             inst_new_idx,
    input  logic             idx_load_done,
    output logic             idx_load_ready,
    output logic             switch_idx_buf,
    output logic             agu_start,
    input  logic             agu_done,
    output logic [2:0]       agu_mode,
    output logic [7:0]       agu_idx_cnt,
    output logic [7:0]       agu_trip_cnt,
    output logic             agu_is_new,
    output logic [3:0]       agu_pad_code,
    output logic             agu_cut_y,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic             sched_idle
);

    localparam int FLD_W = PE_INST_W - 1;

    sched_state_e     state_q;
    sched_state_e     state_d;
    logic             shadow_full_q;
    logic             shadow_full_d;
    logic [FLD_W-1:0] fields_q;
    logic [FLD_W-1:0] fields_d;
    logic [CNT_W-1:0] issued_q;
    logic [CNT_W-1:0] issued_d;
    logic [CNT_W-1:0] done_q;
    logic [CNT_W-1:0] done_d;

    pe_inst_t in_inst;
    pe_inst_t head;
    logic     fifo_full;
    logic     fifo_empty;
    logic     pop;

    assign in_inst = '{
        mode:     inst_mode,
        idx_cnt:  inst_idx_cnt,
        trip_cnt: inst_trip_cnt,
        is_new:   inst_is_new,
        pad_code: inst_pad_code,
        cut_y:    inst_cut_y,
        new_idx:  inst_new_idx
    };

    pe_inst_fifo #(
        .DEPTH (INST_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inst_valid),
        .din   (in_inst),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        shadow_full_d = shadow_full_q;
        fields_d      = fields_q;
        issued_d      = issued_q;
        done_d        = done_q;
        pop           = 1'b0;
        if (idx_load_done) shadow_full_d = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                // Hold a new-index head until the loader has filled the shadow half
                if (!fifo_empty && agu_done &&
                    !(head.new_idx && !shadow_full_q)) begin
                    pop      = 1'b1;
                    fields_d = head[PE_INST_W-1:1];
                    state_d  = head.new_idx ? S_SWITCH : S_START;
                end
            end
            S_SWITCH: begin
                shadow_full_d = 1'b0;
                state_d       = S_START;
            end
            S_START: begin
                issued_d = issued_q + 1'b1;
                state_d  = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (agu_done) begin
                    done_d  = done_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shadow_full_q <= 1'b0;
            fields_q      <= '0;
            issued_q      <= '0;
            done_q        <= '0;
        end else begin
            state_q       <= state_d;
            shadow_full_q <= shadow_full_d;
            fields_q      <= fields_d;
            issued_q      <= issued_d;
            done_q        <= done_d;
        end
    end

    assign inst_ready     = !fifo_full;
    assign idx_load_ready = !shadow_full_q;
    assign switch_idx_buf = (state_q == S_SWITCH);
    assign agu_start      = (state_q == S_START);
    assign issued_cnt     = issued_q;
    assign done_cnt       = done_q;
    assign sched_idle     = fifo_empty && (state_q == S_IDLE) && agu_done;

    assign {agu_mode, agu_idx_cnt, agu_trip_cnt,
            agu_is_new, agu_pad_code, agu_cut_y} = fields_q;

endmodule

// File: tb/tb_pe_agu_sched.sv
// Randomized bench for pe_agu_sched with a queue-based reference model
// and a simple behavioural AGU driving agu_done.
module tb_pe_agu_sched;
    import GLOBAL_PARAM::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_valid;
    logic          inst_ready;
    logic [2:0]    inst_mode;
    logic [7:0]    inst_idx_cnt;
    logic [7:0]    inst_trip_cnt;
    logic          inst_is_new;
    logic [3:0]    inst_pad_code;
    logic          inst_cut_y;
    logic          inst_new_idx;
    logic          idx_load_done;
    logic          idx_load_ready;
    logic          switch_idx_buf;
    logic          agu_start;
    logic          agu_done;
    logic [2:0]    agu_mode;
    logic [7:0]    agu_idx_cnt;
    logic [7:0]    agu_trip_cnt;
    logic          agu_is_new;
    logic [3:0]    agu_pad_code;
    logic          agu_cut_y;
    logic [CW-1:0] issued_cnt;
    logic [CW-1:0] done_cnt;
    logic          sched_idle;

    always #5 clk = ~clk;

    pe_agu_sched #(
        .INST_DEPTH (4),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_mode      (inst_mode),
        .inst_idx_cnt   (inst_idx_cnt),
        .inst_trip_cnt  (inst_trip_cnt),
        .inst_is_new    (inst_is_new),
        .inst_pad_code  (inst_pad_code),
        .inst_cut_y     (inst_cut_y),
        .inst_new_idx   (inst_new_idx),
        .idx_load_done  (idx_load_done),
        .idx_load_ready (idx_load_ready),
        .switch_idx_buf (switch_idx_buf),
        .agu_start      (agu_start),
        .agu_done       (agu_done),
        .agu_mode       (agu_mode),
        .agu_idx_cnt    (agu_idx_cnt),
        .agu_trip_cnt   (agu_trip_cnt),
        .agu_is_new     (agu_is_new),
        .agu_pad_code   (agu_pad_code),
        .agu_cut_y      (agu_cut_y),
        .issued_cnt     (issued_cnt),
        .done_cnt       (done_cnt),
        .sched_idle     (sched_idle)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    pe_inst_t    q[$];
    int          starts;
    logic        mshadow;
    logic        prev_sw;
    logic [24:0] last_f;
    int          busy;
    logic        pend;
    int          agu_lat;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pe_inst_t rand_inst(logic nidx);
        pe_inst_t   p;
        logic [1:0] ph;
        int         r;
        r = $urandom_range(2);
        ph = (r == 0) ? PH_FWD : (r == 1) ? PH_BWD : PH_UPD;
        p.mode     = {ph, 1'($urandom_range(1))};
        p.idx_cnt  = 8'($urandom);
        p.trip_cnt = 8'($urandom);
        p.is_new   = 1'($urandom_range(1));
        p.pad_code = 4'($urandom);
        p.cut_y    = 1'($urandom_range(1));
        p.new_idx  = nidx;
        return p;
    endfunction

    task automatic tick();
        pe_inst_t    e;
        logic [24:0] obs;
        // Shadow half: filled by a load, consumed by a swap; loads onto a full half are dropped
        if (switch_idx_buf) mshadow = 1'b0;
        else if (idx_load_done) mshadow = 1'b1;
        @(posedge clk);
        #1;
        if (pend) begin
            agu_done = 1'b0;
            busy = agu_lat;
            pend = 1'b0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) agu_done = 1'b1;
        end
        obs = {agu_mode, agu_idx_cnt, agu_trip_cnt,
               agu_is_new, agu_pad_code, agu_cut_y};
        if (prev_sw) check("start_after_switch", agu_start, 1);
        if (switch_idx_buf) check("switch_needs_load", mshadow, 1);
        if (agu_start) begin
            if (q.size() == 0) begin
                check("start_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                check("start_fields", obs, e[25:1]);
                check("switch_before_start", prev_sw, e.new_idx);
                last_f = e[25:1];
            end
            starts++;
            pend = 1'b1;
        end else if (!switch_idx_buf) begin
            check("fields_held", obs, last_f);
        end
        prev_sw = switch_idx_buf;
    endtask

    task automatic push(pe_inst_t p);
        {inst_mode, inst_idx_cnt, inst_trip_cnt, inst_is_new,
         inst_pad_code, inst_cut_y, inst_new_idx} = p;
        inst_valid = 1'b1;
        if (inst_ready) q.push_back(p);
        tick();
        inst_valid = 1'b0;
    endtask

    task automatic pulse_load();
        idx_load_done = 1'b1;
        tick();
        idx_load_done = 1'b0;
    endtask

    task automatic do_reset(int cyc);
        rst = 1'b1;
        q.delete();
        starts = 0;
        mshadow = 1'b0;
        prev_sw = 1'b0;
        last_f = '0;
        busy = 0;
        pend = 1'b0;
        agu_done = 1'b1;
        inst_valid = 1'b0;
        idx_load_done = 1'b0;
        repeat (cyc) tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(string t);
        check({t, "_inst_ready"}, inst_ready, 1);
        check({t, "_idx_load_ready"}, idx_load_ready, 1);
        check({t, "_agu_start"}, agu_start, 0);
        check({t, "_switch"}, switch_idx_buf, 0);
        check({t, "_issued"}, issued_cnt, 0);
        check({t, "_done"}, done_cnt, 0);
        check({t, "_fields"}, {agu_mode, agu_idx_cnt, agu_trip_cnt,
              agu_is_new, agu_pad_code, agu_cut_y}, 0);
        check({t, "_idle"}, sched_idle, 1);
    endtask

    task automatic drain(logic loads);
        int n;
        n = 0;
        while (!(q.size() == 0 && busy == 0 && !pend && sched_idle)
               && n < 3000) begin
            idx_load_done = loads && ($urandom_range(3) == 0);
            tick();
            n++;
        end
        idx_load_done = 1'b0;
        check("drain_in_time", n < 3000, 1);
        check("drain_issued", issued_cnt, starts % 16);
        check("drain_done", done_cnt, starts % 16);
        check("drain_idle", sched_idle, 1);
    endtask

    initial begin
        pe_inst_t p;
        int       n;
        int       base;
        rst = 1'b1;
        inst_valid = 1'b0;
        {inst_mode, inst_idx_cnt, inst_trip_cnt, inst_is_new,
         inst_pad_code, inst_cut_y, inst_new_idx} = '0;
        idx_load_done = 1'b0;
        agu_done = 1'b1;
        agu_lat = 20;
        do_reset(3);
        check_reset_vals("rst");

        // Single forward instruction: start two cycles after push
        p = rand_inst(1'b0);
        p.mode = {PH_FWD, 1'b0};
        p.idx_cnt = 8'd8;
        push(p);
        n = 1;
        while (!agu_start && n < 100) begin
            tick();
            n++;
        end
        check("t1_latency", n, 2);
        drain(1'b0);
        check("t1_done_cnt", done_cnt, 1);

        // New index set with no load: stall, then swap and start
        p = rand_inst(1'b1);
        base = starts;
        push(p);
        repeat (50) tick();
        check("t2_stall", starts, base);
        check("t2_ld_ready_hi", idx_load_ready, 1);
        pulse_load();
        check("t2_ld_ready_lo", idx_load_ready, 0);
        n = 0;
        while (!switch_idx_buf && n < 20) begin
            tick();
            n++;
        end
        check("t2_switch_seen", switch_idx_buf, 1);
        tick();
        check("t2_start", agu_start, 1);
        check("t2_switch_one", switch_idx_buf, 0);
        check("t2_ld_ready_back", idx_load_ready, 1);
        drain(1'b0);

        // Fill the FIFO behind a busy AGU
        agu_lat = 30;
        base = starts;
        for (int k = 0; k < 6; k++) begin
            p = rand_inst(1'b0);
            check($sformatf("t3_ready_%0d", k), inst_ready, (k < 5) ? 1 : 0);
            push(p);
        end
        drain(1'b0);
        check("t3_count", starts - base, 5);

        // Second load onto a full shadow is dropped
        agu_lat = 5;
        base = starts;
        pulse_load();
        check("t4_ld_ready_lo", idx_load_ready, 0);
        pulse_load();
        check("t4_ld_ready_still", idx_load_ready, 0);
        push(rand_inst(1'b1));
        push(rand_inst(1'b1));
        repeat (60) tick();
        check("t4_one_started", starts - base, 1);
        check("t4_one_queued", q.size(), 1);
        pulse_load();
        drain(1'b0);
        check("t4_both", starts - base, 2);

        // Reset while waiting on the AGU with two queued
        agu_lat = 40;
        push(rand_inst(1'b0));
        n = 0;
        while (!agu_start && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        push(rand_inst(1'b0));
        push(rand_inst(1'b0));
        do_reset(1);
        check_reset_vals("t5");
        repeat (30) tick();
        check("t5_no_start", starts, 0);

        // Counter wrap with a 4-bit counter
        agu_lat = 2;
        n = 0;
        while (n < 17) begin
            if (inst_ready) begin
                push(rand_inst(1'b0));
                n++;
            end else begin
                tick();
            end
        end
        drain(1'b0);
        check("t6_issued_wrap", issued_cnt, 1);
        check("t6_done_wrap", done_cnt, 1);

        // Random traffic with random loads and AGU latency
        for (int i = 0; i < 150; i++) begin
            agu_lat = $urandom_range(1, 8);
            idx_load_done = ($urandom_range(4) == 0);
            if ($urandom_range(1) == 1) push(rand_inst(1'($urandom_range(1))));
            else tick();
            idx_load_done = 1'b0;
        end
        drain(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
